// File: rtl/ocra1_pkg.sv
// Shared channel codes, word layout, scheduler state codes and word-building helpers.
package ocra1_pkg;

   localparam logic [1:0] CH_X  = 2'd0;
   localparam logic [1:0] CH_Y  = 2'd1;
   localparam logic [1:0] CH_Z  = 2'd2;
   localparam logic [1:0] CH_Z2 = 2'd3;

   localparam int BCAST_BIT = 24;
   localparam int CH_LSB    = 25;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_IDLE = 2'd2;
   localparam logic [1:0] ST_SETTLE    = 2'd3;

   function automatic logic [31:0] ocra1_word(input logic [1:0] ch, input logic bcast,
                                              input logic [23:0] payload);
      logic [31:0] w;
      w                = '0;
      w[23:0]          = payload;
      w[BCAST_BIT]     = bcast;
      w[CH_LSB +: 2]   = ch;
      return w;
   endfunction

   function automatic logic [1:0] next_ch(input logic [3:0] mask);
      if (mask[0])      return CH_X;
      else if (mask[1]) return CH_Y;
      else if (mask[2]) return CH_Z;
      else              return CH_Z2;
   endfunction

   // True when at most one channel bit is set.
   function automatic logic one_left(input logic [3:0] mask);
      return (mask & (mask - 4'd1)) == 4'd0;
   endfunction

endpackage

// File: rtl/ocra1_update_sched.sv
// Arbitrates g/c gradient bundles and serialises masked channels into 32-bit words; ack one cycle
// after request, first word one cycle after ack; the broadcast word waits for busy_i low.
module ocra1_update_sched
   import ocra1_pkg::*;
#(
   parameter int GAP       = 0,
   parameter int SETTLE    = 4,
   parameter int STALL_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        g_req_i,
   input  logic [3:0]  g_mask_i,
   input  logic [95:0] g_data_i,
   output logic        g_ack_o,
   input  logic        c_req_i,
   input  logic [3:0]  c_mask_i,
   input  logic [95:0] c_data_i,
   output logic        c_ack_o,
   output logic [31:0] data_o,
   output logic        valid_o,
   input  logic        busy_i,
   input  logic        data_lost_i,
   output logic        sched_busy_o,
   output logic        late_o,
   output logic        err_lost_o,
   input  logic        clear_err_i
);

   localparam logic [7:0] GAP_W       = 8'(GAP);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] STALL_W     = 8'(STALL_MAX);
   localparam logic [7:0] WAIT_SAT    = 8'(STALL_MAX + 1);

   logic [1:0]  state, state_nxt;
   logic [95:0] bundle;
   logic [3:0]  rem, rem_after, req_mask;
   logic [7:0]  gap_cnt, settle_cnt, wait_cnt;
   logic [1:0]  cur_ch;
   logic [23:0] payload;
   logic        g_take, c_take, take, emit_mid, emit_last;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A request is never taken while an ack is still showing, so a held request cannot be re-acked.
   always_comb begin
      g_take       = (state == ST_IDLE) && g_req_i && !g_ack_o && !c_ack_o;
      c_take       = (state == ST_IDLE) && c_req_i && !g_req_i && !g_ack_o && !c_ack_o;
      take         = g_take | c_take;
      req_mask     = g_take ? g_mask_i : c_mask_i;
      cur_ch       = next_ch(rem);
      rem_after    = rem & ~(4'b0001 << cur_ch);
      emit_mid     = (state == ST_SEND) && (gap_cnt == 8'd0);
      emit_last    = (state == ST_WAIT_IDLE) && (gap_cnt == 8'd0) && !busy_i;
      sched_busy_o = (state != ST_IDLE);
      case (cur_ch)
         CH_X:    payload = bundle[23:0];
         CH_Y:    payload = bundle[47:24];
         CH_Z:    payload = bundle[71:48];
         default: payload = bundle[95:72];
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (take && req_mask != 4'd0)
               state_nxt = one_left(req_mask) ? ST_WAIT_IDLE : ST_SEND;
         ST_SEND:
            if (emit_mid && one_left(rem_after)) state_nxt = ST_WAIT_IDLE;
         ST_WAIT_IDLE:
            if (emit_last) state_nxt = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;
         ST_SETTLE:
            if (settle_cnt == SETTLE_LAST) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bundle     <= '0;
         rem        <= '0;
         gap_cnt    <= '0;
         settle_cnt <= '0;
         wait_cnt   <= '0;
         g_ack_o    <= 1'b0;
         c_ack_o    <= 1'b0;
         valid_o    <= 1'b0;
         data_o     <= '0;
         late_o     <= 1'b0;
         err_lost_o <= 1'b0;
      end else begin
         g_ack_o <= g_take;
         c_ack_o <= c_take;
         if (take) begin
            bundle <= g_take ? g_data_i : c_data_i;
            rem    <= req_mask;
         end else if (emit_mid || emit_last) begin
            rem <= rem_after;
         end
         valid_o <= emit_mid | emit_last;
         data_o  <= (emit_mid | emit_last) ? ocra1_word(cur_ch, emit_last, payload) : '0;
         // Gap spacing also applies across bundle boundaries.
         if (emit_mid || emit_last)  gap_cnt <= GAP_W;
         else if (gap_cnt != 8'd0)   gap_cnt <= gap_cnt - 8'd1;
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
         if (!g_req_i || g_take || g_ack_o) wait_cnt <= 8'd0;
         else if (wait_cnt != WAIT_SAT)      wait_cnt <= wait_cnt + 8'd1;
         late_o     <= (wait_cnt > STALL_W) | (late_o & ~clear_err_i);
         err_lost_o <= data_lost_i | (err_lost_o & ~clear_err_i);
      end
   end

endmodule

// File: tb/tb_ocra1_update_sched.sv
// Bench for ocra1_update_sched: directed scenarios with literal checks plus randomized traffic
// compared every cycle against a queue-based transaction model.
module tb_ocra1_update_sched;

   localparam int M_GAP    = 0;
   localparam int M_SETTLE = 4;
   localparam int M_STALL  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        g_req_i, c_req_i, busy_i, data_lost_i, clear_err_i;
   logic [3:0]  g_mask_i, c_mask_i;
   logic [95:0] g_data_i, c_data_i;

   logic        g_ack_o, c_ack_o, valid_o, sched_busy_o, late_o, err_lost_o;
   logic [31:0] data_o;
   logic        x_g_ack, x_c_ack, x_valid, x_busy, x_late, x_err;
   logic [31:0] x_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ocra1_update_sched u_dut (
      .clk(clk), .rst_n(rst_n),
      .g_req_i(g_req_i), .g_mask_i(g_mask_i), .g_data_i(g_data_i), .g_ack_o(g_ack_o),
      .c_req_i(c_req_i), .c_mask_i(c_mask_i), .c_data_i(c_data_i), .c_ack_o(c_ack_o),
      .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i), .data_lost_i(data_lost_i),
      .sched_busy_o(sched_busy_o), .late_o(late_o), .err_lost_o(err_lost_o),
      .clear_err_i(clear_err_i)
   );

   ocra1_update_sched #(.GAP(2)) u_gap (
      .clk(clk), .rst_n(rst_n),
      .g_req_i(g_req_i), .g_mask_i(g_mask_i), .g_data_i(g_data_i), .g_ack_o(x_g_ack),
      .c_req_i(c_req_i), .c_mask_i(c_mask_i), .c_data_i(c_data_i), .c_ack_o(x_c_ack),
      .data_o(x_data), .valid_o(x_valid), .busy_i(busy_i), .data_lost_i(data_lost_i),
      .sched_busy_o(x_busy), .late_o(x_late), .err_lost_o(x_err),
      .clear_err_i(clear_err_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_word(int ch, bit bc, logic [23:0] p);
      return (32'(ch) << 25) | (32'(bc) << 24) | {8'h00, p};
   endfunction

   // Transaction model: pending words of the accepted bundle, cycle of last word, cycle of return to idle.
   logic [31:0] m_q[$];
   bit          m_xfer, m_done_ok, m_late, m_err;
   int          m_done, m_take, m_last_v, m_wait;
   bit          e_g_ack, e_c_ack, e_valid, e_busy, e_late, e_err;
   logic [31:0] e_data;

   always @(posedge clk) begin : model
      int          t;
      bit          gt, ct, set_late;
      logic [3:0]  mk;
      logic [95:0] dd;
      t = cyc;
      if (!rst_n) begin
         m_q.delete();
         m_xfer = 0; m_done_ok = 0; m_late = 0; m_err = 0;
         m_done = 0; m_take = -1; m_last_v = -1000; m_wait = 0;
         e_g_ack = 0; e_c_ack = 0; e_valid = 0; e_busy = 0; e_late = 0; e_err = 0; e_data = '0;
      end else begin
         if (m_xfer && m_done_ok && t >= m_done) m_xfer = 0;
         gt = !m_xfer && !(e_g_ack || e_c_ack) && g_req_i;
         ct = !m_xfer && !(e_g_ack || e_c_ack) && c_req_i && !g_req_i;
         e_valid = 0;
         e_data  = '0;
         if (m_xfer && m_q.size() > 0 && t > m_take && t >= m_last_v + M_GAP) begin
            if (m_q.size() > 1 || !busy_i) begin
               e_valid  = 1;
               e_data   = m_q.pop_front();
               m_last_v = t + 1;
               if (m_q.size() == 0) begin
                  m_done    = t + 1 + M_SETTLE;
                  m_done_ok = 1;
               end
            end
         end
         if (gt || ct) begin
            mk = gt ? g_mask_i : c_mask_i;
            dd = gt ? g_data_i : c_data_i;
            m_take = t;
            for (int ch = 0; ch < 4; ch++)
               if (mk[ch]) m_q.push_back(mk_word(ch, 1'b0, dd[ch*24 +: 24]));
            if (m_q.size() > 0) begin
               m_q[m_q.size()-1] = m_q[m_q.size()-1] | 32'h0100_0000;
               m_xfer    = 1;
               m_done_ok = 0;
            end
         end
         set_late = (m_wait > M_STALL);
         m_late   = set_late || (m_late && !clear_err_i);
         m_err    = data_lost_i || (m_err && !clear_err_i);
         if (!g_req_i || gt || e_g_ack) m_wait = 0;
         else if (m_wait < M_STALL + 1) m_wait = m_wait + 1;
         e_g_ack = gt;
         e_c_ack = ct;
         e_late  = m_late;
         e_err   = m_err;
         e_busy  = m_xfer && !(m_done_ok && t + 1 >= m_done);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("g_ack", 32'(g_ack_o), 32'(e_g_ack));
         chk("c_ack", 32'(c_ack_o), 32'(e_c_ack));
         chk("valid", 32'(valid_o), 32'(e_valid));
         if (e_valid) chk("data", data_o, e_data);
         chk("sched_busy", 32'(sched_busy_o), 32'(e_busy));
         chk("late", 32'(late_o), 32'(e_late));
         chk("err_lost", 32'(err_lost_o), 32'(e_err));
         chk("ack_exclusive", 32'(g_ack_o & c_ack_o), 32'd0);
      end
   end

   logic [31:0] t1_exp [4] = '{32'h0000_0001, 32'h0200_0002, 32'h0400_0003, 32'h0700_0004};
   int found;

   initial begin
      rst_n = 1'b0; g_req_i = 0; c_req_i = 0; busy_i = 0; data_lost_i = 0; clear_err_i = 0;
      g_mask_i = '0; c_mask_i = '0; g_data_i = '0; c_data_i = '0;
      tick;
      chk_en = 1'b1;
      tick;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy", 32'(sched_busy_o), 32'd0);
      rst_n = 1'b1;
      tick;

      // All four channels, back-to-back, last word broadcast
      g_req_i = 1; g_mask_i = 4'hF; g_data_i = {24'd4, 24'd3, 24'd2, 24'd1};
      tick; chk("t1_ack", 32'(g_ack_o), 32'd1); g_req_i = 0;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("t1_valid", 32'(valid_o), 32'd1);
         chk("t1_data", data_o, t1_exp[k]);
      end
      repeat (8) tick;
      chk("t1_idle", 32'(sched_busy_o), 32'd0);

      // Broadcast word held off while the serialiser is busy
      busy_i = 1; g_req_i = 1; g_mask_i = 4'b0101;
      g_data_i = {24'h0, 24'h123456, 24'h0, 24'hABCDEF};
      tick; chk("t2_ack", 32'(g_ack_o), 32'd1); g_req_i = 0;
      tick; chk("t2_x_valid", 32'(valid_o), 32'd1); chk("t2_x_data", data_o, 32'h00AB_CDEF);
      for (int k = 3; k <= 20; k++) begin
         tick;
         if (k == 20) busy_i = 0;
         chk("t2_hold", 32'(valid_o), 32'd0);
      end
      tick; chk("t2_z_valid", 32'(valid_o), 32'd1); chk("t2_z_data", data_o, 32'h0512_3456);
      repeat (6) tick;

      // Simultaneous requests: g wins, c waits for g's settle
      g_req_i = 1; c_req_i = 1; g_mask_i = 4'b0001; c_mask_i = 4'b0010;
      g_data_i = {4{24'h111111}}; c_data_i = {4{24'h222222}};
      tick;
      chk("t3_g_ack", 32'(g_ack_o), 32'd1);
      chk("t3_c_noack", 32'(c_ack_o), 32'd0);
      g_req_i = 0;
      found = -1;
      for (int k = 2; k < 40 && found < 0; k++) begin
         tick;
         if (c_ack_o) begin found = k; c_req_i = 0; end
      end
      chk("t3_c_ack_cycle", 32'(found), 32'd7);
      repeat (10) tick;

      // late_o while c is stuck in WAIT_IDLE; set wins over clear
      busy_i = 1; c_req_i = 1; c_mask_i = 4'b1000;
      tick; chk("t4_c_ack", 32'(c_ack_o), 32'd1); c_req_i = 0;
      tick; tick;
      g_req_i = 1; g_mask_i = 4'hF;
      for (int k = 4; k <= 21; k++) begin
         tick;
         if (k == 20) chk("t4_late_early", 32'(late_o), 32'd0);
         if (k == 21) chk("t4_late_set", 32'(late_o), 32'd1);
      end
      clear_err_i = 1;
      tick; clear_err_i = 0; chk("t4_set_wins", 32'(late_o), 32'd1); g_req_i = 0;
      tick; clear_err_i = 1;
      tick; clear_err_i = 0; chk("t4_cleared", 32'(late_o), 32'd0);
      busy_i = 0;
      repeat (8) tick;

      // GAP=2 instance: spacing, then reset between words
      rst_n = 0; repeat (2) tick; rst_n = 1;
      g_req_i = 1; g_mask_i = 4'b0011; g_data_i = {24'h0, 24'h0, 24'h00BEEF, 24'h000CAB};
      tick; chk("t5_ack", 32'(x_g_ack), 32'd1); g_req_i = 0;
      for (int k = 2; k <= 5; k++) begin
         tick;
         chk("t5_spacing", 32'(x_valid), 32'(k == 2 || k == 5));
         if (k == 2) chk("t5_w0", x_data, 32'h0000_0CAB);
         if (k == 5) chk("t5_w1", x_data, 32'h0300_BEEF);
      end
      repeat (8) tick;
      g_req_i = 1;
      tick; g_req_i = 0;
      tick; chk("t5_first", 32'(x_valid), 32'd1);
      tick; rst_n = 0;
      tick; rst_n = 1;
      chk("t5_rst_out", {x_data[24:0], x_g_ack, x_c_ack, x_valid, x_busy, x_late, x_err}, 32'd0);
      for (int k = 5; k <= 12; k++) begin
         tick;
         chk("t5_no_word", 32'(x_valid), 32'd0);
         chk("t5_idle", 32'(x_busy), 32'd0);
      end

      // data_lost pulse and mask==0 request
      data_lost_i = 1; g_req_i = 1; g_mask_i = 4'b0000;
      tick; data_lost_i = 0;
      chk("t6_err", 32'(err_lost_o), 32'd1);
      chk("t6_ack", 32'(g_ack_o), 32'd1);
      chk("t6_notbusy", 32'(sched_busy_o), 32'd0);
      g_req_i = 0;
      for (int k = 2; k <= 5; k++) begin
         tick;
         chk("t6_err_hold", 32'(err_lost_o), 32'd1);
         chk("t6_no_valid", 32'(valid_o), 32'd0);
      end
      clear_err_i = 1;
      tick; clear_err_i = 0; chk("t6_err_clr", 32'(err_lost_o), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         tick;
         if (g_ack_o) g_req_i = 0;
         else if (g_req_i && $urandom_range(0, 39) == 0) g_req_i = 0;
         else if (!g_req_i && $urandom_range(0, 5) == 0) begin
            g_req_i = 1; g_mask_i = 4'($urandom); g_data_i = {$urandom, $urandom, $urandom};
         end
         if (c_ack_o) c_req_i = 0;
         else if (!c_req_i && $urandom_range(0, 5) == 0) begin
            c_req_i = 1; c_mask_i = 4'($urandom); c_data_i = {$urandom, $urandom, $urandom};
         end
         if ($urandom_range(0, 7) == 0) busy_i = ~busy_i;
         data_lost_i = ($urandom_range(0, 49) == 0);
         clear_err_i = ($urandom_range(0, 29) == 0);
         rst_n       = ($urandom_range(0, 499) != 0);
      end
      g_req_i = 0; c_req_i = 0; busy_i = 0; data_lost_i = 0; clear_err_i = 0; rst_n = 1;
      repeat (20) tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
